// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at accept time and committed to HI/LO after the op latency.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        cancel,
  input  logic        hilo_we,
  input  logic        hilo_sel,
  input  logic        rd_lo,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             accept, mt_write, commit;
  logic [31:0]      pend_hi, pend_lo;
  logic             pend_wr;

  logic [63:0]      prod_s, prod_u;
  logic             signed_div;
  logic [31:0]      abs_a, abs_b, div_b, quot_u, rem_u, quot, rem;
  logic [31:0]      res_hi, res_lo;
  logic             res_wr;

  // Signed division works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  always_comb begin
    prod_s     = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    prod_u     = {32'b0, src_a} * {32'b0, src_b};
    signed_div = !op[0];
    abs_a      = (signed_div && src_a[31]) ? -src_a : src_a;
    abs_b      = (signed_div && src_b[31]) ? -src_b : src_b;
    div_b      = (abs_b == 32'd0) ? 32'd1 : abs_b;
    quot_u     = abs_a / div_b;
    rem_u      = abs_a % div_b;
    quot       = (signed_div && (src_a[31] ^ src_b[31])) ? -quot_u : quot_u;
    rem        = (signed_div && src_a[31]) ? -rem_u : rem_u;
    if (!op[1]) begin
      {res_hi, res_lo} = op[0] ? prod_u : prod_s;
      res_wr           = 1'b1;
    end else begin
      res_hi = rem;
      res_lo = quot;
      res_wr = (src_b != 32'd0);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    commit     = 1'b0;
    accept     = start && !cancel && (state == IDLE);
    mt_write   = hilo_we && !cancel && (state == IDLE) && !start;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = BUSY;
          cnt_next   = op[1] ? DIV_LOAD : MULT_LOAD;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else if (accept) begin
      pend_hi <= res_hi;
      pend_lo <= res_lo;
      pend_wr <= res_wr;
    end
  end

  // Commit and mthi/mtlo are mutually exclusive: one needs BUSY, the other IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      if (pend_wr) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (mt_write) begin
      if (hilo_sel) hi <= src_a;
      else          lo <= src_a;
    end
  end

  assign busy  = (state == BUSY);
  assign rdata = rd_lo ? lo : hi;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized ops
// compared against a plain-arithmetic reference model of HI/LO and busy timing.
module tb_mult_div_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, cancel, hilo_we, hilo_sel, rd_lo;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy;
  logic [31:0] hi, lo, rdata;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .cancel(cancel),
    .hilo_we(hilo_we), .hilo_sel(hilo_sel), .rd_lo(rd_lo),
    .src_a(src_a), .src_b(src_b),
    .busy(busy), .hi(hi), .lo(lo), .rdata(rdata)
  );

  always #5 clk = ~clk;

  // Returns {writes_hilo, hi, lo}.
  function automatic logic [64:0] refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      2'b00: return {1'b1, 64'(sa * sb)};
      2'b01: return {1'b1, ua * ub};
      2'b10: begin
        if (b == 32'd0) return {1'b0, 64'd0};
        q = sa / sb;
        r = sa % sb;
        return {1'b1, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {1'b0, 64'd0};
        return {1'b1, 32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic we, input logic sel, input logic cn);
    start    = st;
    op       = o;
    src_a    = a;
    src_b    = b;
    hilo_we  = we;
    hilo_sel = sel;
    cancel   = cn;
    tick();
    start    = 1'b0;
    hilo_we  = 1'b0;
    cancel   = 1'b0;
    op       = 2'($urandom);
    hilo_sel = 1'($urandom);
    src_a    = $urandom;
    src_b    = $urandom;
  endtask

  task automatic checkState(input string tag, input logic exp_busy);
    checkOutput({tag, " busy"}, {31'b0, busy}, {31'b0, exp_busy});
    checkOutput({tag, " hi"}, hi, exp_hi);
    checkOutput({tag, " lo"}, lo, exp_lo);
  endtask

  // disturb: 0 none, 1 mthi/mtlo while busy, 2 start on the commit edge, 3 hilo_we with start
  task automatic doOp(input string tag, input logic [1:0] o, input logic [31:0] a,
                      input logic [31:0] b, input int disturb);
    logic [64:0] res;
    int          n;
    res = refModel(o, a, b);
    n   = o[1] ? DIV_N : MULT_N;
    applyStimulus(1'b1, o, a, b, disturb == 3, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      checkState({tag, " inflight"}, 1'b1);
      if (disturb == 1 && i == 1) begin
        hilo_we  = 1'b1;
        hilo_sel = 1'($urandom);
        src_a    = $urandom;
      end
      if (disturb == 2 && i == n - 1) begin
        start = 1'b1;
        op    = 2'($urandom);
        src_a = $urandom;
        src_b = $urandom;
      end
      tick();
      hilo_we = 1'b0;
      start   = 1'b0;
    end
    if (res[64]) begin
      exp_hi = res[63:32];
      exp_lo = res[31:0];
    end
    checkState({tag, " done"}, 1'b0);
    rd_lo = 1'($urandom);
    #1;
    checkOutput({tag, " rdata"}, rdata, rd_lo ? exp_lo : exp_hi);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b0; start = 1'b0; cancel = 1'b0; hilo_we = 1'b0; hilo_sel = 1'b0;
    rd_lo = 1'b1; op = 2'b00; src_a = 32'd0; src_b = 32'd0;
    #12;
    checkState("reset", 1'b0);
    checkOutput("reset rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    doOp("mult -3*7", 2'b00, 32'hFFFF_FFFD, 32'd7, 0);
    doOp("multu max*max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    doOp("mult -1*-1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    doOp("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    doOp("divu 7/0", 2'b11, 32'd7, 32'd0, 0);
    doOp("div 7/0", 2'b10, 32'd7, 32'd0, 0);
    doOp("div minint/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    doOp("div 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 0);

    applyStimulus(1'b0, 2'b00, 32'h0000_1234, 32'd0, 1'b1, 1'b0, 1'b0);
    exp_lo = 32'h0000_1234;
    rd_lo  = 1'b1;
    #1;
    checkState("mtlo", 1'b0);
    checkOutput("mtlo rdata", rdata, 32'h0000_1234);
    applyStimulus(1'b0, 2'b00, 32'hCAFE_0001, 32'd0, 1'b1, 1'b1, 1'b0);
    exp_hi = 32'hCAFE_0001;
    rd_lo  = 1'b0;
    #1;
    checkOutput("mthi rdata", rdata, 32'hCAFE_0001);

    doOp("mthi while busy", 2'b00, 32'd11, 32'd13, 1);
    applyStimulus(1'b1, 2'b00, 32'd5, 32'd6, 1'b0, 1'b0, 1'b1);
    checkState("start cancelled", 1'b0);
    applyStimulus(1'b0, 2'b00, 32'h5555_AAAA, 32'd0, 1'b1, 1'b0, 1'b1);
    checkState("mtlo cancelled", 1'b0);
    doOp("start while busy", 2'b01, 32'h0001_0003, 32'h0002_0005, 2);
    doOp("start with mthi", 2'b10, 32'd100, 32'd7, 3);

    // Asynchronous reset partway through a divide must discard the pending result.
    applyStimulus(1'b1, 2'b10, 32'd1000, 32'd3, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    checkState("async reset", 1'b0);
    #2 rst = 1'b1;
    repeat (DIV_N + 2) tick();
    checkState("no stale commit", 1'b0);
    doOp("mult after reset", 2'b00, 32'h1234_5678, 32'h8765_4321, 0);

    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        ra = $urandom;
        rb = {31'b0, 1'($urandom)};
        applyStimulus(1'b0, 2'b00, ra, 32'd0, 1'b1, rb[0], 1'b0);
        if (rb[0]) exp_hi = ra;
        else       exp_lo = ra;
        checkState("random mt", 1'b0);
      end else begin
        ro = 2'($urandom);
        ra = $urandom;
        case ($urandom_range(0, 3))
          0:       rb = 32'd0;
          1:       rb = 32'($urandom_range(1, 9)) * ($urandom_range(0, 1) == 1 ? 32'hFFFF_FFFF : 32'd1);
          default: rb = $urandom;
        endcase
        doOp("random op", ro, ra, rb, int'($urandom_range(0, 3)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
